// File: rtl/led_pattern_drv.sv
// Purpose : turns the 10-bit run counter into a board LED pattern (PASS/SCAN/BREATHE/BAR).
// Latency : cnt_in -> led_out is 2 clocks in every mode; mode requests apply on a PWM period boundary.
// Backpr. : none; cnt_in is sampled every cycle and mode_load is a fire-and-forget strobe.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   cnt_in[9:0]     run counter from the upstream stage, may change any cycle
//   mode_in[1:0]    requested mode (0 PASS, 1 SCAN, 2 BREATHE, 3 BAR)
//   mode_load       one-cycle strobe capturing mode_in
//   led_out[9:0]    registered LED drive, 1 = lit
//   mode_cur[1:0]   mode currently applied
//   mode_ack        one-cycle pulse in the cycle after a mode is applied
module led_pattern_drv #(
    parameter int PWM_BITS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] cnt_in,
    input  logic [1:0] mode_in,
    input  logic       mode_load,
    output logic [9:0] led_out,
    output logic [1:0] mode_cur,
    output logic       mode_ack
);

    localparam logic [1:0] MODE_PASS    = 2'd0;
    localparam logic [1:0] MODE_SCAN    = 2'd1;
    localparam logic [1:0] MODE_BREATHE = 2'd2;
    localparam logic [1:0] MODE_BAR     = 2'd3;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    logic [9:0]          cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic [1:0]          mode_cur_q, mode_cur_d;
    logic                pend_vld_q, pend_vld_d;
    logic [1:0]          pend_mode_q, pend_mode_d;
    logic                mode_ack_q;
    logic [3:0]          pos_q, pos_d;
    logic                dir_q, dir_d;
    logic [9:0]          led_q, led_d;

    logic                step;
    logic                boundary;
    logic                apply;
    logic [1:0]          new_mode;
    logic [PWM_BITS-1:0] duty;
    logic [3:0]          bar_n;
    logic [9:0]          bar_pat;

    assign step      = (cnt_in != cnt_q);
    assign boundary  = &pwm_cnt_q;
    assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

    // A load arriving in the boundary cycle itself bypasses the pending slot.
    assign apply    = boundary && (pend_vld_q || mode_load);
    assign new_mode = mode_load ? mode_in : pend_mode_q;

    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_mode_d = pend_mode_q;
        if (mode_load) begin
            pend_mode_d = mode_in;
        end
        if (apply) begin
            pend_vld_d = 1'b0;
        end else if (mode_load) begin
            pend_vld_d = 1'b1;
        end
        mode_cur_d = apply ? new_mode : mode_cur_q;
    end

    // Scan position: re-entry into SCAN restarts the sweep and wins over a step.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (apply && (new_mode == MODE_SCAN)) begin
            pos_d = 4'd0;
            dir_d = DIR_UP;
        end else if (step && (mode_cur_q == MODE_SCAN)) begin
            if (dir_q == DIR_UP) begin
                if (pos_q == 4'd9) begin
                    pos_d = 4'd8;
                    dir_d = DIR_DN;
                end else begin
                    pos_d = pos_q + 4'd1;
                end
            end else begin
                if (pos_q == 4'd0) begin
                    pos_d = 4'd1;
                    dir_d = DIR_UP;
                end else begin
                    pos_d = pos_q - 4'd1;
                end
            end
        end
    end

    // Breathing folds the counter's top bit into a triangle so brightness ramps up then down.
    assign duty  = cnt_q[9] ? ~cnt_q[8 -: PWM_BITS] : cnt_q[8 -: PWM_BITS];
    // Raw bar values 10..15 saturate to a full bar.
    assign bar_n = (cnt_q[9:6] > 4'd10) ? 4'd10 : cnt_q[9:6];

    always_comb begin
        for (int i = 0; i < 10; i++) begin
            bar_pat[i] = (4'(i) < bar_n);
        end
    end

    always_comb begin
        led_d = '0;
        case (mode_cur_q)
            MODE_PASS:    led_d = cnt_q;
            MODE_SCAN:    led_d = 10'd1 << pos_q;
            MODE_BREATHE: led_d = {10{pwm_cnt_q < duty}};
            MODE_BAR:     led_d = bar_pat;
            default:      led_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            pwm_cnt_q   <= '0;
            mode_cur_q  <= MODE_PASS;
            pend_vld_q  <= 1'b0;
            pend_mode_q <= MODE_PASS;
            mode_ack_q  <= 1'b0;
            pos_q       <= 4'd0;
            dir_q       <= DIR_UP;
            led_q       <= '0;
        end else begin
            cnt_q       <= cnt_in;
            pwm_cnt_q   <= pwm_cnt_d;
            mode_cur_q  <= mode_cur_d;
            pend_vld_q  <= pend_vld_d;
            pend_mode_q <= pend_mode_d;
            mode_ack_q  <= apply;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            led_q       <= led_d;
        end
    end

    assign led_out  = led_q;
    assign mode_cur = mode_cur_q;
    assign mode_ack = mode_ack_q;

endmodule
